// File: rtl/double_to_long_pkg.sv
// Shared constants, state encoding and unpacked-operand type for the
// binary64 -> int64 converter.
package double_to_long_pkg;

  localparam int          DBL_EXP_BIAS = 1023;
  localparam logic [10:0] DBL_EXP_MAX  = 11'h7FF;
  localparam logic [63:0] INT64_MIN    = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    UNPACK  = 3'd1,
    SPECIAL = 3'd2,
    CONVERT = 3'd3,
    PACK    = 3'd4,
    PUT_Z   = 3'd5
  } state_t;

  // mant is left-aligned: value = mant * 2^(exp - 63)
  typedef struct packed {
    logic               sign;
    logic signed [11:0] exp;
    logic [63:0]        mant;
    logic               is_inf_nan;
    logic               is_too_big;
    logic               is_frac;
  } unpacked_t;

endpackage

// File: rtl/double_to_long_unpack.sv
// Combinational binary64 field split: sign, unbiased exponent, left-aligned
// mantissa and the classification flags used by integer converters.
module double_to_long_unpack
  import double_to_long_pkg::*;
(
  input  logic [63:0] a,
  output unpacked_t   u
);

  logic [10:0]        exp_field;
  logic signed [11:0] exp_unb;

  always_comb begin
    exp_field    = a[62:52];
    exp_unb      = $signed({1'b0, exp_field}) - $signed(12'(DBL_EXP_BIAS));
    u.sign       = a[63];
    u.exp        = exp_unb;
    u.mant       = {1'b1, a[51:0], 11'b0};
    u.is_inf_nan = (exp_field == DBL_EXP_MAX);
    // Magnitude >= 2^63 saturates; magnitude < 1 (zero, denormals) truncates to 0.
    u.is_too_big = (exp_unb >= 12'sd63);
    u.is_frac    = (exp_unb < 12'sd0);
  end

endmodule

// File: rtl/double_to_long.sv
// binary64 -> signed int64 with truncation toward zero; multi-cycle FSM that
// right-shifts the left-aligned mantissa until the exponent reaches 63.
module double_to_long
  import double_to_long_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output logic [2:0]  dbg_state
);

  // Handshake: a word moves on a rising edge where stb and ack are both 1;
  // the side that raised ack/stb drops it in the cycle after that edge.

  state_t             state, state_nxt;
  logic [63:0]        a_reg;
  logic               s_reg;
  logic signed [11:0] e_reg;
  logic [63:0]        m_reg;
  logic               inf_nan_reg, too_big_reg, frac_reg;
  logic [63:0]        z_reg;
  logic               ack_reg, stb_reg;
  logic               ack_nxt, stb_nxt;
  unpacked_t          u;

  logic               in_xfer, out_xfer;
  logic signed [11:0] e_gap;
  logic [6:0]         step;
  logic signed [11:0] e_step;
  logic [63:0]        m_step;

  double_to_long_unpack u_unpack (
    .a (a_reg),
    .u (u)
  );

  assign in_xfer      = input_a_stb && ack_reg;
  assign out_xfer     = stb_reg && output_z_ack;
  assign input_a_ack  = ack_reg;
  assign output_z_stb = stb_reg;
  assign output_z     = z_reg;
  assign dbg_state    = state;

  // Shift never overshoots: the last step only closes the remaining gap to 63.
  always_comb begin
    e_gap = 12'sd63 - e_reg;
    if (e_gap < $signed(12'(SHIFT_PER_CYCLE))) step = e_gap[6:0];
    else                                        step = 7'(SHIFT_PER_CYCLE);
    e_step = e_reg + $signed({5'd0, step});
    m_step = m_reg >> step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GET_A;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GET_A:   if (in_xfer) state_nxt = UNPACK;
      UNPACK:  state_nxt = SPECIAL;
      SPECIAL: begin
        if (inf_nan_reg || too_big_reg || frac_reg) state_nxt = PUT_Z;
        else                                        state_nxt = CONVERT;
      end
      CONVERT: if (e_step == 12'sd63) state_nxt = PACK;
      PACK:    state_nxt = PUT_Z;
      PUT_Z:   if (out_xfer) state_nxt = GET_A;
      default: state_nxt = GET_A;
    endcase
  end

  // ack follows the next state so it reopens right after an output transfer;
  // stb follows the current state, giving one settle cycle in PUT_Z.
  always_comb begin
    ack_nxt = (state_nxt == GET_A);
    stb_nxt = (state == PUT_Z) && !out_xfer;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_reg <= 1'b0;
      stb_reg <= 1'b0;
    end else begin
      ack_reg <= ack_nxt;
      stb_reg <= stb_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg       <= '0;
      s_reg       <= 1'b0;
      e_reg       <= '0;
      m_reg       <= '0;
      inf_nan_reg <= 1'b0;
      too_big_reg <= 1'b0;
      frac_reg    <= 1'b0;
      z_reg       <= '0;
    end else begin
      case (state)
        GET_A: if (in_xfer) a_reg <= input_a;
        UNPACK: begin
          s_reg       <= u.sign;
          e_reg       <= u.exp;
          m_reg       <= u.mant;
          inf_nan_reg <= u.is_inf_nan;
          too_big_reg <= u.is_too_big;
          frac_reg    <= u.is_frac;
        end
        SPECIAL: begin
          if (inf_nan_reg || too_big_reg) z_reg <= INT64_MIN;
          else if (frac_reg)              z_reg <= '0;
        end
        CONVERT: begin
          m_reg <= m_step;
          e_reg <= e_step;
        end
        PACK:    z_reg <= s_reg ? (64'd0 - m_reg) : m_reg;
        default: ;
      endcase
    end
  end

endmodule
